// File: rtl/pick_flux_scheduler.sv
// pick_flux_scheduler: round-robin grant of one stream's selector token, then one data token from the port it names, onto a shared output.
// Latency: selector read at N, data read at N+1, output write at N+2; peak one token every 3 cycles.
// Backpressure: out0_full holds the token in OUT with data/tag stable and no reads issued; build with PICK_SEL_CHECK_EN to discard out-of-range selectors and pulse err.

module pick_flux_scheduler #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    parameter int PORTS = 2
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic [FLUX-1:0]          nda_empty,
    output logic [FLUX-1:0]          nda_read,
    input  logic [WIDTH-1:0]         nda_data,
    input  logic [PORTS*FLUX-1:0]    in_empty,
    output logic [PORTS*FLUX-1:0]    in_read,
    input  logic [PORTS*WIDTH-1:0]   in_data,
    input  logic                     out0_full,
    output logic                     out0_wr,
    output logic [WIDTH-1:0]         out0_data,
    output logic [FLUX-1:0]          out0_flux,
    output logic                     err
);

    localparam int CW = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int NB = PORTS * FLUX;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [WIDTH-1:0] PORTS_W = WIDTH'(PORTS);
    localparam logic [CW-1:0]    LAST    = CW'(FLUX - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        DATA = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   cur;
    logic [WIDTH-1:0] sel;
    // Low for the first cycle after reset release so no strobe fires before state settles.
    logic            run;

    logic            found;
    logic            found_hi;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   grant_hi;
    logic [CW-1:0]   grant_lo;

    logic [PW-1:0]   port_idx;
    logic [IW-1:0]   in_bit;
    logic            data_rdy;
    logic [WIDTH-1:0] in_word;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == LAST) ? '0 : v + CW'(1);
    endfunction

    // Round-robin search: lowest pending stream at or above rr_ptr, otherwise lowest pending overall (wrap).
    always_comb begin
        found    = 1'b0;
        found_hi = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (!nda_empty[f]) begin
                found    = 1'b1;
                grant_lo = CW'(f);
                if (CW'(f) >= rr_ptr) begin
                    found_hi = 1'b1;
                    grant_hi = CW'(f);
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    // Decode the latched selector into a port and the flat data-FIFO bit of the current stream.
    always_comb begin
        port_idx = PW'(sel % PORTS_W);
        in_bit   = IW'(int'(cur) * PORTS + int'(port_idx));
        in_word  = '0;
        data_rdy = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (PW'(p) == port_idx) in_word = in_data[p*WIDTH +: WIDTH];
        end
        for (int b = 0; b < NB; b++) begin
            if (IW'(b) == in_bit) data_rdy = ~in_empty[b];
        end
    end

    // Strobes are combinational on the current state so each FIFO read lands in the cycle its data is valid.
    always_comb begin
        nda_read = '0;
        in_read  = '0;
        out0_wr  = 1'b0;
        if (run) begin
            case (state)
                ARB: begin
                    if (found) begin
                        for (int f = 0; f < FLUX; f++) begin
                            if (CW'(f) == grant) nda_read[f] = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (data_rdy) begin
                        for (int b = 0; b < NB; b++) begin
                            if (IW'(b) == in_bit) in_read[b] = 1'b1;
                        end
                    end
                end
                OUT:     out0_wr = ~out0_full;
                default: ;
            endcase
        end
    end

`ifdef PICK_SEL_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Scheduler FSM: ARB grants a selector, DATA fetches its token, OUT presents it until accepted.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            sel       <= '0;
            cur       <= '0;
            out0_data <= '0;
            out0_flux <= '0;
            run       <= 1'b0;
`ifdef PICK_SEL_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            run <= 1'b1;
`ifdef PICK_SEL_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state)
                ARB: begin
                    if (|nda_read) begin
                        sel <= nda_data;
                        cur <= grant;
`ifdef PICK_SEL_CHECK_EN
                        // Out-of-range selector: drop it, flag it, and move the pointer past this stream.
                        if (nda_data >= PORTS_W) begin
                            err_q  <= 1'b1;
                            rr_ptr <= wrap_inc(grant);
                            state  <= ARB;
                        end else begin
                            state  <= DATA;
                        end
`else
                        state <= DATA;
`endif
                    end
                end
                DATA: begin
                    if (|in_read) begin
                        out0_data <= in_word;
                        out0_flux <= FLUX'(1) << cur;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out0_wr) begin
                        rr_ptr <= wrap_inc(cur);
                        state  <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_pick_flux_scheduler.sv
// Bench for pick_flux_scheduler: behavioural selector/data FIFOs, table-driven single transactions,
// hand-written reset/throughput/stall/wait/selector-range sequences, and an output scoreboard.
// Outputs are sampled on the falling edge; FIFO pops and stimulus changes happen just after the rising edge.

module tb_pick_flux_scheduler;

    localparam int W = 8;
    localparam int F = 2;
    localparam int P = 2;

    logic              ck = 1'b0;
    logic              rst;
    logic [F-1:0]      nda_empty;
    logic [F-1:0]      nda_read;
    logic [W-1:0]      nda_data;
    logic [P*F-1:0]    in_empty;
    logic [P*F-1:0]    in_read;
    logic [P*W-1:0]    in_data;
    logic              out0_full;
    logic              out0_wr;
    logic [W-1:0]      out0_data;
    logic [F-1:0]      out0_flux;
    logic              err;

    always #5 ck = ~ck;

    pick_flux_scheduler #(.WIDTH(W), .FLUX(F), .PORTS(P)) dut (
        .ck(ck), .rst(rst),
        .nda_empty(nda_empty), .nda_read(nda_read), .nda_data(nda_data),
        .in_empty(in_empty), .in_read(in_read), .in_data(in_data),
        .out0_full(out0_full), .out0_wr(out0_wr),
        .out0_data(out0_data), .out0_flux(out0_flux), .err(err)
    );

    // Behavioural FIFOs
    logic [7:0] sel_mem [F][32];
    logic [4:0] sel_wp [F];
    logic [4:0] sel_rp [F];
    logic [7:0] dat_mem [F*P][32];
    logic [4:0] dat_wp [F*P];
    logic [4:0] dat_rp [F*P];

    always_comb begin
        nda_empty = '1;
        in_empty  = '1;
        nda_data  = '0;
        in_data   = '0;
        for (int f = 0; f < F; f++) begin
            nda_empty[f] = (sel_wp[f] == sel_rp[f]);
            if (nda_read[f] && (sel_wp[f] != sel_rp[f])) nda_data = sel_mem[f][sel_rp[f]];
        end
        for (int b = 0; b < F*P; b++) in_empty[b] = (dat_wp[b] == dat_rp[b]);
        for (int f = 0; f < F; f++) begin
            if (|in_read[f*P +: P]) begin
                for (int p = 0; p < P; p++) begin
                    if (dat_wp[f*P+p] != dat_rp[f*P+p]) in_data[p*W +: W] = dat_mem[f*P+p][dat_rp[f*P+p]];
                end
            end
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] flux;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int         f;
        logic [7:0] sel;
        logic [7:0] dat;
        logic [1:0] exp_nda;
        logic [3:0] exp_in;
        logic [7:0] exp_data;
        logic [1:0] exp_flux;
    } vec_t;
    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int nda_cyc, in_cyc, wr_cyc;
    logic [1:0] nda_val, wr_flux;
    logic [3:0] in_val;
    logic [7:0] wr_data;
    int wr_log[$];

    logic [1:0] s_nda;
    logic [3:0] s_in;
    logic       s_wr;
    logic [7:0] s_data;
    logic [1:0] s_flux;
    logic       s_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_trk();
        nda_cyc = -1; in_cyc = -1; wr_cyc = -1;
        nda_val = '0; in_val = '0; wr_data = '0; wr_flux = '0;
    endtask

    task automatic push_data(input int b, input logic [7:0] d);
        dat_mem[b][dat_wp[b]] = d;
        dat_wp[b] = dat_wp[b] + 5'd1;
    endtask

    task automatic push_txn(input int f, input logic [7:0] s, input logic [7:0] d,
                            input bit with_data, input bit with_sb);
        sel_mem[f][sel_wp[f]] = s;
        sel_wp[f] = sel_wp[f] + 5'd1;
        if (with_data) push_data(f*P + (int'(s) % P), d);
        if (with_sb) sb.push_back('{data: d, flux: 2'(1 << f)});
    endtask

    task automatic flush();
        for (int f = 0; f < F; f++) sel_rp[f] = sel_wp[f];
        for (int b = 0; b < F*P; b++) dat_rp[b] = dat_wp[b];
    endtask

    // One clock: sample on the falling edge, score writes, then pop FIFOs just after the rising edge.
    task automatic step();
        sb_t e;
        @(negedge ck);
        cyc++;
        s_nda = nda_read; s_in = in_read; s_wr = out0_wr;
        s_data = out0_data; s_flux = out0_flux; s_err = err;
        chk("strobe_exclusive", 32'($countones({s_nda, s_in}) <= 1), 1);
        if (s_nda != 0) begin nda_cyc = cyc; nda_val = s_nda; end
        if (s_in != 0) begin in_cyc = cyc; in_val = s_in; end
        if (s_err) err_pulses++;
        if (s_wr) begin
            wr_cyc = cyc; wr_data = s_data; wr_flux = s_flux;
            wr_log.push_back(cyc);
            if (sb.size() == 0) chk("sb_unexpected_write", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_data", s_data, e.data);
                chk("sb_flux", s_flux, e.flux);
            end
        end
        @(posedge ck);
        #1;
        for (int f = 0; f < F; f++) if (s_nda[f] && sel_rp[f] != sel_wp[f]) sel_rp[f] = sel_rp[f] + 5'd1;
        for (int b = 0; b < F*P; b++) if (s_in[b] && dat_rp[b] != dat_wp[b]) dat_rp[b] = dat_rp[b] + 5'd1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() > 0; k++) step();
        chk(name, sb.size(), 0);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        clear_trk();
        push_txn(v.f, v.sel, v.dat, 1, 1);
        for (int k = 0; k < 12 && wr_cyc < 0; k++) step();
        chk({name, "_wr_seen"}, 32'(wr_cyc >= 0), 1);
        chk({name, "_nda"}, nda_val, v.exp_nda);
        chk({name, "_in"}, in_val, v.exp_in);
        chk({name, "_lat_in"}, in_cyc - nda_cyc, 1);
        chk({name, "_lat_wr"}, wr_cyc - nda_cyc, 2);
        chk({name, "_data"}, wr_data, v.exp_data);
        chk({name, "_flux"}, wr_flux, v.exp_flux);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        out0_full = 1'b0;
        for (int f = 0; f < F; f++) begin sel_wp[f] = '0; sel_rp[f] = '0; end
        for (int b = 0; b < F*P; b++) begin dat_wp[b] = '0; dat_rp[b] = '0; end

        vecs[0] = '{0, 8'd1, 8'hA5, 2'b01, 4'b0010, 8'hA5, 2'b01};
        vecs[1] = '{1, 8'd0, 8'h3C, 2'b10, 4'b0100, 8'h3C, 2'b10};
        vecs[2] = '{0, 8'd0, 8'h11, 2'b01, 4'b0001, 8'h11, 2'b01};
        vecs[3] = '{1, 8'd1, 8'hFF, 2'b10, 4'b1000, 8'hFF, 2'b10};
        vecs[4] = '{0, 8'd0, 8'h00, 2'b01, 4'b0001, 8'h00, 2'b01};
        vecs[5] = '{1, 8'd1, 8'h80, 2'b10, 4'b1000, 8'h80, 2'b10};
        vecs[6] = '{0, 8'd1, 8'h5C, 2'b01, 4'b0010, 8'h5C, 2'b01};

        // Reset state, and no strobes while held in reset even with a pending selector
        #12;
        chk("reset_outputs", {nda_read, in_read, out0_wr, out0_data, out0_flux, err}, 0);
        push_txn(1, 8'd0, 8'h5A, 1, 1);
        #10;
        chk("reset_no_strobe", {nda_read, in_read, out0_wr}, 0);
        @(posedge ck);
        #1;
        rst = 1'b1;
        step();
        chk("release_quiet", {s_nda, s_in, s_wr}, 0);
        step();
        chk("release_grant", s_nda, 2'b10);
        drain("release_drain", 6);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while a token sits in OUT; rr_ptr is 1 here, so a stream-0 grant proves it was cleared
        clear_trk();
        push_txn(1, 8'd0, 8'h99, 1, 0);
        out0_full = 1'b1;
        for (int k = 0; k < 6 && in_cyc < 0; k++) step();
        chk("mid_reached_out", 32'(in_cyc >= 0), 1);
        rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {nda_read, in_read, out0_wr, out0_data, out0_flux, err}, 0);
        out0_full = 1'b0;
        flush();
        push_txn(0, 8'd0, 8'h21, 1, 1);
        push_txn(1, 8'd1, 8'h43, 1, 1);
        step();
        chk("mid_reset_strobes", {s_nda, s_in, s_wr}, 0);
        rst = 1'b1;
        step();
        chk("mid_release_quiet", {s_nda, s_in, s_wr}, 0);
        step();
        chk("mid_first_grant", s_nda, 2'b01);
        drain("mid_drain", 10);

        // Both streams saturated: alternating grants, one write every 3 cycles
        push_txn(0, 8'd0, 8'h01, 1, 1);
        push_txn(1, 8'd1, 8'h02, 1, 1);
        push_txn(0, 8'd1, 8'h03, 1, 1);
        push_txn(1, 8'd0, 8'h04, 1, 1);
        wr_log.delete();
        for (int k = 0; k < 20 && wr_log.size() < 4; k++) step();
        chk("tput_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            for (int i = 1; i < 4; i++) chk($sformatf("tput_gap%0d", i), wr_log[i] - wr_log[i-1], 3);
        end

        // Output stall for 5 cycles
        clear_trk();
        out0_full = 1'b1;
        push_txn(0, 8'd1, 8'hC3, 1, 1);
        for (int k = 0; k < 6 && nda_cyc < 0; k++) step();
        chk("stall_grant", nda_val, 2'b01);
        step();
        chk("stall_in", s_in, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_no_wr", s_wr, 0);
            chk("stall_hold", {s_data, s_flux}, {8'hC3, 2'b01});
            chk("stall_no_read", {s_nda, s_in}, 0);
        end
        out0_full = 1'b0;
        step();
        chk("stall_release_wr", s_wr, 1);

        // Stream 1 waits in DATA for its token; stream 0 must not be served meanwhile
        push_txn(1, 8'd0, 8'h6E, 0, 1);
        push_txn(0, 8'd1, 8'h4B, 1, 1);
        step();
        chk("wait_grant", s_nda, 2'b10);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wait_idle", {s_nda, s_in}, 0);
        end
        push_data(2, 8'h6E);
        step();
        chk("wait_read", s_in, 4'b0100);
        drain("wait_drain", 12);

        // Out-of-range selector
`ifdef PICK_SEL_CHECK_EN
        push_txn(1, 8'd3, 8'h00, 0, 0);
        step();
        chk("range_grant", s_nda, 2'b10);
        step();
        chk("range_err", s_err, 1);
        chk("range_no_io", {s_in, s_wr}, 0);
        step();
        chk("range_err_drop", s_err, 0);
        chk("range_quiet", {s_nda, s_in, s_wr}, 0);
        run_txn(vecs[0], "range_after");
        chk("err_pulses", err_pulses, 1);
`else
        begin
            vec_t v;
            v = '{1, 8'd3, 8'hD2, 2'b10, 4'b1000, 8'hD2, 2'b10};
            run_txn(v, "range_mod");
        end
        chk("err_never", err_pulses, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pick_flux_scheduler.md
PICK_FLUX_SCHEDULER -- requirements
Module: pick_flux_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, token data width.
REQ-002 SHALL have parameter FLUX, default 2, number of independent streams (2..8).
REQ-003 SHALL have parameter PORTS, default 2, number of data input channels per stream (2..8).
REQ-004 SHALL have port ck, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port nda_empty, input, FLUX, per-stream selector FIFO empty.
REQ-007 SHALL have port nda_read, output, FLUX, per-stream selector read strobe.
REQ-008 SHALL have port nda_data, input, WIDTH, selector token; valid in the cycle its nda_read bit is high.
REQ-009 SHALL have port in_empty, input, PORTS*FLUX, data FIFO empty; bit f*PORTS+p = stream f, port p.
REQ-010 SHALL have port in_read, output, PORTS*FLUX, data read strobe; same bit mapping as in_empty.
REQ-011 SHALL have port in_data, input, PORTS*WIDTH, port p data at [p*WIDTH +: WIDTH]; valid in the cycle it is read.
REQ-012 SHALL have port out0_full, input, 1, shared output channel full.
REQ-013 SHALL have port out0_wr, output, 1, output write strobe.
REQ-014 SHALL have port out0_data, output, WIDTH, registered output token.
REQ-015 SHALL have port out0_flux, output, FLUX, one-hot stream tag of out0_data.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on a discarded selector.

Function
REQ-017 SHALL implement FSM states ARB, DATA, OUT.
REQ-018 In ARB: SHALL select the first stream f, searching from rr_ptr upward with wrap, with nda_empty[f]=0; assert nda_read[f] in that cycle; latch sel=nda_data, cur=f; go to DATA. If no candidate: stay in ARB, no strobes.
REQ-019 In DATA: when in_empty[cur*PORTS+sel]=0, SHALL assert in_read at that bit for one cycle, latch in_data port sel into out0_data, set out0_flux=onehot(cur), and go to OUT; otherwise SHALL wait with no strobes and serve no other stream.
REQ-020 In OUT: out0_wr SHALL equal NOT out0_full (combinational); on out0_wr=1 SHALL go to ARB and set rr_ptr=(cur+1) mod FLUX; out0_data and out0_flux SHALL hold stable while stalled.
REQ-021 SHALL assert at most one bit across nda_read and in_read in any cycle.
REQ-022 Minimum latency: nda_read at cycle N, in_read at N+1, out0_wr at N+2; peak throughput one token per 3 cycles.
REQ-023 Round-robin: a stream with a pending selector SHALL be granted within FLUX grants.
REQ-024 Strobes SHALL be deasserted in all cycles not listed above.

Reset
REQ-025 rst=0 SHALL immediately force state=ARB, rr_ptr=0, sel=0, cur=0, out0_data=0, out0_flux=0, err=0; nda_read, in_read and out0_wr SHALL be 0 while rst=0.
REQ-026 Reset mid-operation SHALL drop any in-flight token; no read or write strobe SHALL be issued in the first cycle after release.

Configuration
REQ-027 Macro PICK_SEL_CHECK_EN defined: a selector with value >= PORTS SHALL be discarded in the cycle after its read (DATA skipped); err SHALL pulse for one cycle; FSM SHALL return to ARB; rr_ptr SHALL advance past cur.
REQ-028 Macro PICK_SEL_CHECK_EN undefined: port index SHALL be sel mod PORTS; err SHALL be tied 0.

Verification (WIDTH=8, FLUX=2, PORTS=2)
REQ-029 Drive rst=0 mid-transfer -> all outputs 0 at once; after release, first grant goes to stream 0.
REQ-030 Stream 0 selector=1, port-1 data=0xA5 -> nda_read=01 at N, in_read=0010 at N+1, out0_wr=1 with out0_data=0xA5 and out0_flux=01 at N+2.
REQ-031 Both selector FIFOs never empty, all data available -> grant order 0,1,0,1; a token every 3 cycles.
REQ-032 out0_full=1 for 5 cycles in OUT -> out0_wr=0 with data held for 5 cycles; write in cycle 6; no reads during the stall.
REQ-033 Stream 1 selector=0, in_empty[2]=1 for 4 cycles -> FSM stays in DATA; stream 0 not served; in_read[2] issued in cycle 5.
REQ-034 PICK_SEL_CHECK_EN defined, selector=3 -> err pulses 1 cycle, no in_read, no out0_wr, back in ARB; undefined -> port 1 read.
